clear_screen_engine: RTL and testbench
======================================

CLEAR_SCREEN_ENGINE -- requirements
Module: clear_screen_engine

Interface
REQ-001 The module SHALL have parameter WIDTH, default 160, meaning the number of columns swept (x range 0..WIDTH-1).
REQ-002 The module SHALL have parameter HEIGHT, default 120, meaning the number of rows swept (y range 0..HEIGHT-1).
REQ-003 The module SHALL have parameter CLEAR_COLOUR, default 3'b000, meaning the 3-bit colour written to every pixel.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port program_resetn, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port run_clearScreen, input, 1 bit: level request from the main controller, held high for the whole stage.
REQ-008 The module SHALL have port clearScreen_done, output, 1 bit: completion flag returned to the main controller.
REQ-009 The module SHALL have port x, output, 8 bits: pixel column to the VGA adapter.
REQ-010 The module SHALL have port y, output, 7 bits: pixel row to the VGA adapter.
REQ-011 The module SHALL have port colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-012 The module SHALL have port plot, output, 1 bit: write-enable to the VGA adapter.

Function
REQ-013 The module SHALL implement states IDLE, CLEAR and DONE, with all outputs registered.
REQ-014 In IDLE with run_clearScreen=1, the module SHALL, at the next edge, set x=0, y=0, plot=1 and state=CLEAR, so the first pixel is presented 1 cycle after run is sampled.
REQ-015 In CLEAR with run_clearScreen=1, the module SHALL advance x by 1 each cycle; at x=WIDTH-1 it SHALL wrap x to 0 and increment y.
REQ-016 In CLEAR at x=WIDTH-1 and y=HEIGHT-1, the next edge SHALL set plot=0, clearScreen_done=1 and state=DONE, so plot is high for exactly WIDTH*HEIGHT consecutive cycles.
REQ-017 The colour output SHALL equal CLEAR_COLOUR at all times.
REQ-018 In DONE, clearScreen_done SHALL stay 1 while run_clearScreen=1.
REQ-019 In DONE with run_clearScreen=0, the next edge SHALL clear clearScreen_done and return the module to IDLE.
REQ-020 In CLEAR with run_clearScreen=0 (abort), the next edge SHALL set plot=0 and state=IDLE and leave clearScreen_done at 0; no partial done indication is allowed.
REQ-021 After an abort, a new run_clearScreen=1 SHALL restart the sweep from x=0, y=0.
REQ-022 clearScreen_done and plot SHALL never be 1 in the same cycle.
REQ-023 x and y SHALL never exceed WIDTH-1 and HEIGHT-1.
REQ-024 Counter widths SHALL be fixed at 8 bits for x and 7 bits for y; WIDTH<=256 and HEIGHT<=128 are required parameter limits.
REQ-025 In IDLE, plot SHALL be 0 and x and y SHALL hold their last values.

Reset
REQ-026 While program_resetn=0, the module SHALL force state=IDLE, x=0, y=0, plot=0 and clearScreen_done=0, asynchronously and regardless of run_clearScreen or current state.
REQ-027 Reset released mid-sweep SHALL not resume the sweep; a sweep starts only from IDLE with run_clearScreen=1 sampled after release.

Structure
REQ-028 The state encodings and the default VGA geometry (160, 120, colour width 3) SHALL live in the shared project package used by main_controller and the drawing stages.
REQ-029 The module SHALL be a single module with no sub-modules; the x/y sweep counter is inline.

Verification
REQ-030 With WIDTH=4, HEIGHT=3 and run held high, plot SHALL be high for 12 cycles with (x,y) = (0,0),(1,0)..(3,0),(0,1)..(3,2), and clearScreen_done SHALL rise on the cycle after (3,2).
REQ-031 In DONE, holding run high for 5 cycles SHALL keep done=1; after run drops, done SHALL be 0 one edge later, with state IDLE and plot=0.
REQ-032 Dropping run after the 5th plot cycle SHALL give plot=0 and done=0 at the next edge; re-asserting run SHALL restart at (0,0) with a full 12-cycle sweep.
REQ-033 Asserting program_resetn=0 asynchronously mid-sweep at (2,1) SHALL immediately give x=0, y=0, plot=0 and done=0, and no plot SHALL occur until run is sampled after reset release.
REQ-034 With default parameters, plot SHALL be high for exactly 19200 cycles, the last pixel SHALL be (159,119), and colour SHALL be 3'b000 throughout.
REQ-035 A 1-cycle run pulse SHALL give exactly 1 plot cycle at (0,0), then an abort to IDLE with done never asserted.

Source files
------------

// File: rtl/clear_screen_engine_pkg.sv
// Shared project definitions: stage FSM encodings and default VGA geometry.
// Used by main_controller and all drawing stages.
package clear_screen_engine_pkg;

  localparam int VGA_WIDTH  = 160;
  localparam int VGA_HEIGHT = 120;
  localparam int COLOUR_W   = 3;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/clear_screen_engine.sv
// Clear-screen drawing stage: raster-sweeps every pixel once with a fixed colour,
// then holds a done flag until the main controller drops its run request.
module clear_screen_engine
  import clear_screen_engine_pkg::*;
#(
  parameter int                    WIDTH        = VGA_WIDTH,
  parameter int                    HEIGHT       = VGA_HEIGHT,
  parameter logic [COLOUR_W-1:0]   CLEAR_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                program_resetn,
  input  logic                run_clearScreen,
  output logic                clearScreen_done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  // WIDTH must not exceed 256 and HEIGHT must not exceed 128 (fixed counter widths).
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  logic [1:0]     state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           plot_q, plot_d;
  logic           done_q, done_d;

  // x/y always hold the pixel currently presented; they only move while sweeping.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    plot_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_clearScreen) begin
          state_d = ST_CLEAR;
          x_d     = '0;
          y_d     = '0;
          plot_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (!run_clearScreen) begin
          state_d = ST_IDLE;
        end else if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            x_d    = '0;
            y_d    = y_q + 7'd1;
            plot_d = 1'b1;
          end
        end else begin
          x_d    = x_q + 8'd1;
          plot_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (run_clearScreen) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
    end
  end

  assign x                = x_q;
  assign y                = y_q;
  assign plot             = plot_q;
  assign clearScreen_done = done_q;
  assign colour           = CLEAR_COLOUR;

endmodule

// File: tb/tb_clear_screen_engine.sv
// Bench for clear_screen_engine: a 4x3 instance under directed and random run/reset
// traffic plus a default-geometry instance for one full 160x120 sweep.
module tb_clear_screen_engine;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int DW = 160;
  localparam int DH = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       program_resetn;
  logic       run_s, run_d;
  logic       done_s, done_d, plot_s, plot_d;
  logic [7:0] x_s, x_d;
  logic [6:0] y_s, y_d;
  logic [2:0] colour_s, colour_d;

  clear_screen_engine #(.WIDTH(SW), .HEIGHT(SH), .CLEAR_COLOUR(3'b101)) u_small (
    .clk(clk), .program_resetn(program_resetn), .run_clearScreen(run_s),
    .clearScreen_done(done_s), .x(x_s), .y(y_s), .colour(colour_s), .plot(plot_s));

  clear_screen_engine u_dflt (
    .clk(clk), .program_resetn(program_resetn), .run_clearScreen(run_d),
    .clearScreen_done(done_d), .x(x_d), .y(y_d), .colour(colour_d), .plot(plot_d));

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is just a pixel index 0..w*h-1 mapped to (idx%w, idx/w).
  typedef struct {
    bit active;
    bit fin;
    int idx;
    int lx;
    int ly;
  } model_t;

  model_t ms = '{0, 0, 0, 0, 0};
  model_t md = '{0, 0, 0, 0, 0};

  function automatic model_t model_reset();
    model_t m = '{0, 0, 0, 0, 0};
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit run, int w, int h);
    if (m.fin) begin
      if (!run) m.fin = 1'b0;
    end else if (m.active) begin
      if (!run) begin
        m.active = 1'b0;
      end else begin
        m.idx++;
        if (m.idx == w * h) begin
          m.active = 1'b0;
          m.fin    = 1'b1;
        end else begin
          m.lx = m.idx % w;
          m.ly = m.idx / w;
        end
      end
    end else if (run) begin
      m.active = 1'b1;
      m.idx    = 0;
      m.lx     = 0;
      m.ly     = 0;
    end
    return m;
  endfunction

  always @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      ms = model_reset();
      md = model_reset();
    end else begin
      ms = model_step(ms, run_s, SW, SH);
      md = model_step(md, run_d, DW, DH);
    end
  end

  // Per-cycle comparison of both instances against the model and the invariants.
  always @(negedge clk) begin
    if (check_en) begin
      check("s_plot",   int'(plot_s),   int'(ms.active));
      check("s_done",   int'(done_s),   int'(ms.fin));
      check("s_x",      int'(x_s),      ms.lx);
      check("s_y",      int'(y_s),      ms.ly);
      check("s_colour", int'(colour_s), 5);
      check("s_excl",   int'(plot_s & done_s), 0);
      check("d_plot",   int'(plot_d),   int'(md.active));
      check("d_done",   int'(done_d),   int'(md.fin));
      check("d_x",      int'(x_d),      md.lx);
      check("d_y",      int'(y_d),      md.ly);
      check("d_colour", int'(colour_d), 0);
    end
  end

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t log_q[$];
  bit   done_seen = 1'b0;
  int   dcount = 0;
  int   dlx = 0;
  int   dly = 0;

  always @(negedge clk) begin
    if (plot_s) log_q.push_back('{int'(x_s), int'(y_s)});
    if (done_s) done_seen = 1'b1;
    if (plot_d) begin
      dcount++;
      dlx = int'(x_d);
      dly = int'(y_d);
    end
  end

  // Called at negedge+1: drive run and advance n cycles, ending at negedge+1.
  task automatic apply_stimulus(bit v, int n);
    run_s = v;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_sweep_log(string tag);
    int exp_x[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_y[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    check({tag, "_len"}, log_q.size(), 12);
    if (log_q.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check({tag, "_px"}, log_q[i].x, exp_x[i]);
        check({tag, "_py"}, log_q[i].y, exp_y[i]);
      end
    end
  endtask

  initial begin
    program_resetn = 1'b0;
    run_s = 1'b0;
    run_d = 1'b0;
    @(negedge clk);
    #1;
    check_en = 1'b1;
    check("rst_x", int'(x_s), 0);
    check("rst_plot", int'(plot_s), 0);
    check("rst_done", int'(done_s), 0);
    @(negedge clk);
    #1;
    program_resetn = 1'b1;
    apply_stimulus(1'b0, 2);

    // Full sweep with run held, then done hold and release.
    log_q.delete();
    apply_stimulus(1'b1, 13);
    check_sweep_log("sweep");
    check("sweep_done", int'(done_s), 1);
    check("sweep_plot_off", int'(plot_s), 0);
    check("sweep_hold_x", int'(x_s), 3);
    check("sweep_hold_y", int'(y_s), 2);
    apply_stimulus(1'b1, 5);
    check("done_hold", int'(done_s), 1);
    apply_stimulus(1'b0, 1);
    check("done_release", int'(done_s), 0);
    check("release_plot", int'(plot_s), 0);

    // Abort after the 5th plot, then a complete restart.
    apply_stimulus(1'b1, 5);
    check("abort_pre_x", int'(x_s), 0);
    check("abort_pre_y", int'(y_s), 1);
    apply_stimulus(1'b0, 1);
    check("abort_plot", int'(plot_s), 0);
    check("abort_done", int'(done_s), 0);
    log_q.delete();
    apply_stimulus(1'b1, 13);
    check_sweep_log("restart");
    apply_stimulus(1'b0, 2);

    // Asynchronous reset mid-sweep at (2,1).
    apply_stimulus(1'b1, 7);
    check("mid_x", int'(x_s), 2);
    check("mid_y", int'(y_s), 1);
    #2 program_resetn = 1'b0;
    #1;
    check("arst_x", int'(x_s), 0);
    check("arst_y", int'(y_s), 0);
    check("arst_plot", int'(plot_s), 0);
    check("arst_done", int'(done_s), 0);
    @(negedge clk);
    #1;
    program_resetn = 1'b1;
    apply_stimulus(1'b0, 3);
    check("post_rst_plot", int'(plot_s), 0);

    // Single-cycle run pulse.
    log_q.delete();
    done_seen = 1'b0;
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 4);
    check("pulse_len", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("pulse_x", log_q[0].x, 0);
      check("pulse_y", log_q[0].y, 0);
    end
    check("pulse_no_done", int'(done_seen), 0);

    // Random run lengths, gaps and asynchronous reset pulses.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 3));
        program_resetn = 1'b0;
        @(negedge clk);
        #1;
        program_resetn = 1'b1;
      end
      apply_stimulus(1'b1, $urandom_range(1, 20));
      apply_stimulus(1'b0, $urandom_range(1, 4));
    end
    apply_stimulus(1'b0, 2);

    // Default geometry: one complete sweep.
    dcount = 0;
    run_d = 1'b1;
    for (int i = 0; i < 20000 && !done_d; i++) begin
      @(negedge clk);
    end
    #1;
    check("dflt_done_reached", int'(done_d), 1);
    check("dflt_plot_count", dcount, 19200);
    check("dflt_last_x", dlx, 159);
    check("dflt_last_y", dly, 119);
    run_d = 1'b0;
    @(negedge clk);
    #1;
    check("dflt_release", int'(done_d), 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
